// File: rtl/score_pkg.sv
// Shared definitions for the score controller: active-low 7-seg digit patterns,
// FSM state encoding and the BCD increment helper.
package score_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_CMP  = 2'd2
    } state_t;

    // Callers never pass 8'h99; saturation is handled before this is used.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module bcd_to_seg7
    import score_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_ctrl.sv
// Round-robin point-award arbiter with a saturating two-digit BCD score,
// session high score and blinking 7-segment display on a new high score.
module score_ctrl
    import score_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int PTS_W     = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*PTS_W-1:0] pts,
    output logic [N_SRC-1:0]       ack,
    output logic [7:0]             score_bcd,
    output logic [7:0]             hi_bcd,
    output logic                   new_hi,
    output logic                   sat,
    output logic [6:0]             seven_dis,
    output logic [6:0]             seven_dis1
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    state_t           state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n, grant_idx;
    logic             found;
    logic [PTS_W-1:0] cnt, cnt_n;
    logic [7:0]       score_n, hi_n;
    logic             new_hi_n, sat_n;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;
    logic [6:0]       seg_tens, seg_ones;
    int               j;

    // Search starts at ptr and wraps, so the last winner becomes lowest priority.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int i = 0; i < N_SRC; i++) begin
            j = int'(ptr) + i;
            if (j >= N_SRC)
                j = j - N_SRC;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        score_n  = score_bcd;
        hi_n     = hi_bcd;
        new_hi_n = new_hi;
        sat_n    = sat;
        ack      = '0;
        if (clr) begin
            state_n  = ST_IDLE;
            cnt_n    = '0;
            score_n  = 8'h00;
            sat_n    = 1'b0;
            new_hi_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        ack[grant_idx] = 1'b1;
                        cnt_n          = pts[grant_idx*PTS_W +: PTS_W];
                        ptr_n          = (int'(grant_idx) == N_SRC - 1) ? '0
                                                                        : grant_idx + IDX_W'(1);
                        state_n        = ST_ADD;
                    end
                end
                // Leave on the last unit so a request costs pts+2 cycles in total.
                ST_ADD: begin
                    if (cnt == '0) begin
                        state_n = ST_CMP;
                    end else if (score_bcd == 8'h99) begin
                        sat_n   = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_CMP;
                    end else begin
                        score_n = bcd_inc(score_bcd);
                        cnt_n   = cnt - PTS_W'(1);
                        if (cnt == PTS_W'(1))
                            state_n = ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (score_bcd > hi_bcd) begin
                        hi_n     = score_bcd;
                        new_hi_n = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            score_bcd <= 8'h00;
            hi_bcd    <= 8'h00;
            new_hi    <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
            score_bcd <= score_n;
            hi_bcd    <= hi_n;
            new_hi    <= new_hi_n;
            sat       <= sat_n;
        end
    end

    bcd_to_seg7 u_tens (.bcd(score_bcd[7:4]), .seg(seg_tens));
    bcd_to_seg7 u_ones (.bcd(score_bcd[3:0]), .seg(seg_ones));

    // Blink only runs while new_hi is set; otherwise it is parked in the on phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt  <= '0;
            blink_on   <= 1'b1;
            seven_dis  <= SEG_0;
            seven_dis1 <= SEG_0;
        end else begin
            if (clr || !new_hi) begin
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (blink_cnt == BLK_MAX) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
            seven_dis  <= blink_on ? seg_tens : SEG_BLANK;
            seven_dis1 <= blink_on ? seg_ones : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_score_ctrl.sv
// Directed self-checking bench for score_ctrl with a short blink period.
module tb_score_ctrl;

    logic        clk = 1'b0;
    logic        rst, clr;
    logic [3:0]  req;
    logic [15:0] pts;
    logic [3:0]  ack;
    logic [7:0]  score_bcd, hi_bcd;
    logic        new_hi, sat;
    logic [6:0]  seven_dis, seven_dis1;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    score_ctrl #(.N_SRC(4), .PTS_W(4), .BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .req(req), .pts(pts), .ack(ack),
        .score_bcd(score_bcd), .hi_bcd(hi_bcd), .new_hi(new_hi), .sat(sat),
        .seven_dis(seven_dis), .seven_dis1(seven_dis1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one request, release it after the grant edge, then let the FSM settle.
    task automatic award(input int src, input logic [3:0] p, output bit got);
        got = 1'b0;
        @(posedge clk);
        #1;
        req[src]           = 1'b1;
        pts[src*4 +: 4]    = p;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack[src]) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req[src] = 1'b0;
        repeat (int'(p) + 3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; req = '0; pts = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (score_bcd !== 8'h00) begin fails++; $display("[TB] FAIL reset_score: got %h expected 00", score_bcd); end
        checks++;
        if (hi_bcd !== 8'h00) begin fails++; $display("[TB] FAIL reset_hi: got %h expected 00", hi_bcd); end
        checks++;
        if ({seven_dis, seven_dis1} !== {7'b1000000, 7'b1000000}) begin
            fails++; $display("[TB] FAIL reset_digits: got %b %b expected 1000000 1000000", seven_dis, seven_dis1);
        end
        checks++;
        if ({ack, new_hi, sat} !== 6'b0) begin
            fails++; $display("[TB] FAIL reset_flags: ack/new_hi/sat got %b expected 000000", {ack, new_hi, sat});
        end
    endtask

    task automatic test_single_award();
        logic [13:0] exp_disp;
        @(negedge clk);
        req[1] = 1'b1; pts[7:4] = 4'd7;
        #1;
        checks++;
        if (ack !== 4'b0010) begin fails++; $display("[TB] FAIL grant_src1: ack got %b expected 0010", ack); end
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL ack_one_cycle: ack got %b expected 0000", ack); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++;
        if (score_bcd !== 8'h06) begin fails++; $display("[TB] FAIL add_step6: got %h expected 06", score_bcd); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({score_bcd, hi_bcd} !== 16'h0700) begin
            fails++; $display("[TB] FAIL add_final: score/hi got %h expected 0700", {score_bcd, hi_bcd});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({hi_bcd, new_hi} !== {8'h07, 1'b1}) begin
            fails++; $display("[TB] FAIL hi_update: hi %h new_hi %b expected 07 1", hi_bcd, new_hi);
        end
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) @(negedge clk);
            if (k >= 1 && (((k - 1) / 4) % 2) == 1)
                exp_disp = {7'b1111111, 7'b1111111};
            else
                exp_disp = {7'b1000000, 7'b1111000};
            checks++;
            if ({seven_dis, seven_dis1} !== exp_disp) begin
                fails++;
                $display("[TB] FAIL blink_k%0d: got %b expected %b", k, {seven_dis, seven_dis1}, exp_disp);
            end
        end
    endtask

    task automatic test_round_robin();
        int order [4] = '{2, 3, 0, 1};
        int prev = 0;
        bit got;
        logic [3:0] seen;
        @(posedge clk);
        #1;
        req = 4'b1111; pts = 16'h1111;
        for (int n = 0; n < 4; n++) begin
            got  = 1'b0;
            seen = '0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (ack != 4'b0000) begin
                    got  = 1'b1;
                    seen = ack;
                    break;
                end
            end
            checks++;
            if (!got) begin
                fails++; $display("[TB] FAIL rr_timeout_%0d: no ack expected src %0d", n, order[n]);
            end else begin
                if (seen !== 4'(1 << order[n])) begin
                    fails++; $display("[TB] FAIL rr_order_%0d: ack got %b expected src %0d", n, seen, order[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - prev != 3) begin
                        fails++; $display("[TB] FAIL rr_spacing_%0d: got %0d cycles expected 3", n, cyc - prev);
                    end
                end
                prev = cyc;
            end
            @(posedge clk);
            #1 req = req & ~seen;
        end
        req = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (score_bcd !== 8'h11) begin fails++; $display("[TB] FAIL rr_score: got %h expected 11", score_bcd); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (hi_bcd !== 8'h11) begin fails++; $display("[TB] FAIL rr_hi: got %h expected 11", hi_bcd); end
    endtask

    task automatic test_saturation();
        bit got;
        for (int n = 0; n < 5; n++) award(0, 4'd15, got);
        award(0, 4'd9, got);
        checks++;
        if ({score_bcd, sat} !== {8'h95, 1'b0}) begin
            fails++; $display("[TB] FAIL sat_pre: score %h sat %b expected 95 0", score_bcd, sat);
        end
        award(2, 4'd9, got);
        checks++;
        if ({score_bcd, sat, hi_bcd} !== {8'h99, 1'b1, 8'h99}) begin
            fails++; $display("[TB] FAIL sat_clamp: score %h sat %b hi %h expected 99 1 99", score_bcd, sat, hi_bcd);
        end
        award(3, 4'd3, got);
        checks++;
        if ({got, score_bcd, sat} !== {1'b1, 8'h99, 1'b1}) begin
            fails++; $display("[TB] FAIL sat_hold: ack %b score %h sat %b expected 1 99 1", got, score_bcd, sat);
        end
    endtask

    task automatic test_clear();
        bit got;
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({score_bcd, sat, new_hi, hi_bcd} !== {8'h00, 1'b0, 1'b0, 8'h99}) begin
            fails++; $display("[TB] FAIL clr_state: score %h sat %b new_hi %b hi %h expected 00 0 0 99",
                              score_bcd, sat, new_hi, hi_bcd);
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({seven_dis, seven_dis1} !== {7'b1000000, 7'b1000000}) begin
                fails++; $display("[TB] FAIL clr_steady_%0d: got %b %b expected 1000000 1000000", k, seven_dis, seven_dis1);
            end
        end
        @(posedge clk);
        #1;
        req[2] = 1'b1; pts[11:8] = 4'd15;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack[2]) begin got = 1'b1; break; end
        end
        @(posedge clk);
        #1 req[2] = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({got, score_bcd} !== {1'b1, 8'h12}) begin
            fails++; $display("[TB] FAIL abort_pre: ack %b score %h expected 1 12", got, score_bcd);
        end
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({score_bcd, hi_bcd} !== 16'h0099) begin
            fails++; $display("[TB] FAIL abort_post: score/hi got %h expected 0099", {score_bcd, hi_bcd});
        end
        req[3] = 1'b1; pts[15:12] = 4'd0; clr = 1'b1;
        #1;
        checks++;
        if (ack !== 4'b0000) begin fails++; $display("[TB] FAIL clr_blocks_ack: ack got %b expected 0000", ack); end
        @(posedge clk);
        #1 clr = 1'b0;
        #1;
        checks++;
        if (ack !== 4'b1000) begin fails++; $display("[TB] FAIL ack_after_clr: ack got %b expected 1000", ack); end
        @(posedge clk);
        #1 req[3] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (score_bcd !== 8'h00) begin fails++; $display("[TB] FAIL zero_pts: score got %h expected 00", score_bcd); end
    endtask

    task automatic test_bcd_carry();
        bit got;
        award(1, 4'd9, got);
        award(1, 4'd1, got);
        checks++;
        if (score_bcd !== 8'h10) begin fails++; $display("[TB] FAIL carry_09_10: got %h expected 10", score_bcd); end
        award(1, 4'd9, got);
        award(1, 4'd1, got);
        checks++;
        if (score_bcd !== 8'h20) begin fails++; $display("[TB] FAIL carry_19_20: got %h expected 20", score_bcd); end
        for (int n = 0; n < 4; n++) award(1, 4'd15, got);
        award(1, 4'd9, got);
        checks++;
        if (score_bcd !== 8'h89) begin fails++; $display("[TB] FAIL run_to_89: got %h expected 89", score_bcd); end
        award(1, 4'd1, got);
        checks++;
        if ({score_bcd, seven_dis, seven_dis1} !== {8'h90, 7'b0010000, 7'b1000000}) begin
            fails++; $display("[TB] FAIL carry_89_90: score %h digits %b %b expected 90 0010000 1000000",
                              score_bcd, seven_dis, seven_dis1);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        for (int n = 0; n < 3; n++) award(0, 4'd15, got);
        checks++;
        if (score_bcd !== 8'h45) begin fails++; $display("[TB] FAIL run_to_45: got %h expected 45", score_bcd); end
        award(0, 4'd1, got);
        checks++;
        if ({score_bcd, seven_dis, seven_dis1} !== {8'h46, 7'b0011001, 7'b0000010}) begin
            fails++; $display("[TB] FAIL step_45_46: score %h digits %b %b expected 46 0011001 0000010",
                              score_bcd, seven_dis, seven_dis1);
        end
        checks++;
        if ({hi_bcd, new_hi} !== {8'h99, 1'b0}) begin
            fails++; $display("[TB] FAIL hi_kept: hi %h new_hi %b expected 99 0", hi_bcd, new_hi);
        end
    endtask

    initial begin
        $display("[TB] score_ctrl directed test start");
        test_reset();
        test_single_award();
        test_round_robin();
        test_saturation();
        test_clear();
        test_bcd_carry();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
